// File: rtl/shadow_bus_pkg.sv
// Shared constants for the 1801VM2 local-bus controller: region tags,
// startup-mode codes and the startup vector prefix.
package shadow_bus_pkg;

  // full_adr[16:13] values for the two shadow regions (SEL bit included)
  localparam logic [3:0] ROM_TAG_DEF = 4'b1110;
  localparam logic [3:0] RAM_TAG_DEF = 4'b1111;

  // Startup modes sampled from mode_i while dclo is high
  typedef enum logic [2:0] {
    SU_VEC24       = 3'b000,
    SU_CONSOLE     = 3'b001,
    SU_DX_BOOT     = 3'b010,
    SU_ROM_140000  = 3'b011,
    SU_USER_ROM    = 3'b100,
    SU_CONSOLE_ALT = 3'b101,
    SU_ROM_173000  = 3'b110,
    SU_TEST        = 3'b111
  } startup_e;

  // Upper 13 bits of the startup word returned on address-less reads
  localparam logic [12:0] VEC_PREFIX = 13'o14000;

  // Startup word seen by the CPU for a given latched mode
  function automatic logic [15:0] startup_word(input startup_e mode);
    return {VEC_PREFIX, mode};
  endfunction

endpackage

// File: rtl/shadow_bus_ctl_tmr_gate.sv
// 50 Hz timer gate: synchronises the async timer, debounces the on/off
// button on timer ticks and gates the timer event with the enable state.
module tmr_gate #(
  parameter int DEB_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic timer_50,
  input  logic timer_button,
  output logic timer_status,
  output logic evnt_o
);

  logic [2:0]         sync;     // [0],[1] synchroniser, [2] edge-detect history
  logic [DEB_LEN-1:0] deb;
  logic               tbevent;  // set once a full press has been acted upon
  logic               tick;

  assign tick   = sync[1] & ~sync[2];
  assign evnt_o = sync[1] & timer_status;

  // Synchronise, shift the button on each tick, toggle once per full press
  always_ff @(posedge clk) begin
    if (rst) begin
      sync         <= '0;
      deb          <= '0;
      tbevent      <= 1'b0;
      timer_status <= 1'b1;
    end else begin
      sync <= {sync[1:0], timer_50};
      if (tick)
        deb <= DEB_LEN'({deb, timer_button});
      if (deb == '1 && !tbevent) begin
        timer_status <= ~timer_status;
        tbevent      <= 1'b1;
      end else if (deb == '0) begin
        tbevent <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/shadow_bus_ctl.sv
// Local-bus controller for the 1801VM2 board: shadow ROM/RAM decode,
// ROM wait states, global-bus timeout, vector mux, slow clock enable
// and the 50 Hz timer gate.
module shadow_bus_ctl
  import shadow_bus_pkg::*;
#(
  parameter int         ROM_AW   = 12,
  parameter logic [3:0] ROM_TAG  = ROM_TAG_DEF,
  parameter logic [3:0] RAM_TAG  = RAM_TAG_DEF,
  parameter int         ROM_WAIT = 2,
  parameter int         TMO_CYC  = 64,
  parameter int         SLOW_DIV = 22,
  parameter int         DEB_LEN  = 2
) (
  input  logic              clk_p,
  input  logic              dclo,
  input  logic [16:0]       full_adr,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic [15:0]       bus_dat_i,
  input  logic [15:0]       rom_dat_i,
  input  logic              global_ack,
  output logic [15:0]       dat_o,
  output logic              ack_o,
  output logic              bus_cyc_o,
  output logic              rom_stb_o,
  output logic              sysram_stb_o,
  output logic [ROM_AW-1:0] rom_adr_o,
  output logic              bus_err_o,
  input  logic              una_i,
  input  logic [15:0]       ivec_i,
  input  logic              istb_i,
  input  logic              iack_i,
  input  logic [2:0]        mode_i,
  output logic [15:0]       vector_o,
  output logic              istb_o,
  output logic              vack_o,
  input  logic              cpuslow,
  output logic              clk_ena_o,
  input  logic              timer_50,
  input  logic              timer_button,
  output logic              timer_status,
  output logic              evnt_o
);

  localparam int            TW        = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam bit            TMO_EN    = (TMO_CYC > 0);
  localparam logic [TW-1:0] TMO_LAST  = TW'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);
  localparam logic [3:0]    WAIT_LAST = 4'(ROM_WAIT - 1);
  localparam logic [7:0]    DIV_LAST  = 8'(SLOW_DIV - 1);

  logic [3:0]    wcnt;
  logic          rom_ack_q;
  logic [TW-1:0] tcnt;
  logic          tmo_ack;
  logic          tmo_run;
  logic [7:0]    cnt;
  startup_e      startup_q;
  logic          unused_adr;

  // Byte-address bit is not part of the ROM word address
  assign unused_adr = full_adr[0];

  assign rom_stb_o    = stb_i & cyc_i & (full_adr[16:13] == ROM_TAG);
  assign sysram_stb_o = stb_i & cyc_i & (full_adr[16:13] == RAM_TAG);
  assign bus_cyc_o    = cyc_i & ~full_adr[16];
  assign rom_adr_o    = full_adr[ROM_AW:1];
  assign dat_o        = rom_stb_o ? rom_dat_i : bus_dat_i;
  assign tmo_run      = bus_cyc_o & stb_i & ~global_ack;

  // global_ack is combinational so it still reaches the CPU during dclo
  assign ack_o = global_ack | (rom_ack_q & rom_stb_o) | (tmo_ack & stb_i);

  assign vector_o  = una_i ? startup_word(startup_q) : ivec_i;
  assign istb_o    = istb_i & ~una_i;
  assign vack_o    = iack_i | una_i;
  assign clk_ena_o = ~cpuslow | (cnt == 8'd0);

  // ROM wait-state counter; any strobe gap restarts the count
  always_ff @(posedge clk_p) begin
    if (dclo || !rom_stb_o) begin
      wcnt      <= '0;
      rom_ack_q <= 1'b0;
    end else if (!rom_ack_q) begin
      if (wcnt == WAIT_LAST)
        rom_ack_q <= 1'b1;
      else
        wcnt <= wcnt + 4'd1;
    end
  end

  // Global-bus timeout; a same-cycle global_ack stops tmo_run and wins
  always_ff @(posedge clk_p) begin
    if (dclo) begin
      tcnt      <= '0;
      tmo_ack   <= 1'b0;
      bus_err_o <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      if (!stb_i)
        tmo_ack <= 1'b0;
      if (!tmo_run) begin
        tcnt <= '0;
      end else if (TMO_EN && !tmo_ack) begin
        if (tcnt == TMO_LAST) begin
          bus_err_o <= 1'b1;
          tmo_ack   <= 1'b1;
          tcnt      <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

  // Slow-mode divider; held at zero so enabling it fires immediately
  always_ff @(posedge clk_p) begin
    if (dclo || !cpuslow)
      cnt <= 8'd0;
    else if (cnt == DIV_LAST)
      cnt <= 8'd0;
    else
      cnt <= cnt + 8'd1;
  end

  // Startup mode follows mode_i throughout reset and freezes on release
  always_ff @(posedge clk_p) begin
    if (dclo)
      startup_q <= startup_e'(mode_i);
  end

  tmr_gate #(
    .DEB_LEN(DEB_LEN)
  ) u_tmr_gate (
    .clk          (clk_p),
    .rst          (dclo),
    .timer_50     (timer_50),
    .timer_button (timer_button),
    .timer_status (timer_status),
    .evnt_o       (evnt_o)
  );

endmodule

// File: tb/tb_shadow_bus_ctl.sv
// Directed bench for shadow_bus_ctl with default parameters.
module tb_shadow_bus_ctl;

  logic        clk_p = 1'b0;
  logic        dclo;
  logic [16:0] full_adr;
  logic        cyc_i, stb_i;
  logic [15:0] bus_dat_i, rom_dat_i;
  logic        global_ack;
  logic [15:0] dat_o;
  logic        ack_o, bus_cyc_o, rom_stb_o, sysram_stb_o;
  logic [11:0] rom_adr_o;
  logic        bus_err_o;
  logic        una_i;
  logic [15:0] ivec_i;
  logic        istb_i, iack_i;
  logic [2:0]  mode_i;
  logic [15:0] vector_o;
  logic        istb_o, vack_o;
  logic        cpuslow, clk_ena_o;
  logic        timer_50, timer_button, timer_status, evnt_o;

  int errors = 0;
  int checks = 0;
  int pulses, pulse_at, ones, first_one;

  always #5 clk_p = ~clk_p;

  shadow_bus_ctl dut (
    .clk_p(clk_p), .dclo(dclo), .full_adr(full_adr), .cyc_i(cyc_i),
    .stb_i(stb_i), .bus_dat_i(bus_dat_i), .rom_dat_i(rom_dat_i),
    .global_ack(global_ack), .dat_o(dat_o), .ack_o(ack_o),
    .bus_cyc_o(bus_cyc_o), .rom_stb_o(rom_stb_o), .sysram_stb_o(sysram_stb_o),
    .rom_adr_o(rom_adr_o), .bus_err_o(bus_err_o), .una_i(una_i),
    .ivec_i(ivec_i), .istb_i(istb_i), .iack_i(iack_i), .mode_i(mode_i),
    .vector_o(vector_o), .istb_o(istb_o), .vack_o(vack_o),
    .cpuslow(cpuslow), .clk_ena_o(clk_ena_o), .timer_50(timer_50),
    .timer_button(timer_button), .timer_status(timer_status), .evnt_o(evnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic cyc();
    @(posedge clk_p);
    #1;
  endtask

  // One 50 Hz period: 4 cycles high, 4 cycles low
  task automatic tmr_tick();
    timer_50 = 1'b1;
    repeat (4) cyc();
    timer_50 = 1'b0;
    repeat (4) cyc();
  endtask

  initial begin
    dclo = 1'b1; full_adr = '0; cyc_i = 0; stb_i = 0; bus_dat_i = 16'h1234;
    rom_dat_i = 16'hBEEF; global_ack = 0; una_i = 0; ivec_i = 16'o000123;
    istb_i = 0; iack_i = 0; mode_i = 3'b011; cpuslow = 0; timer_50 = 0;
    timer_button = 0;
    repeat (3) cyc();
    chk("rst_ack", ack_o, 0);
    chk("rst_err", bus_err_o, 0);
    chk("rst_ena", clk_ena_o, 1);
    chk("rst_tstat", timer_status, 1);
    chk("rst_evnt", evnt_o, 0);
    dclo = 1'b0;
    mode_i = 3'b000;
    cyc();

    // Address-less read returns the startup word latched during reset
    una_i = 1; istb_i = 1; #1;
    chk("una_vec", vector_o, 16'o140003);
    chk("una_vack", vack_o, 1);
    chk("una_istb", istb_o, 0);
    una_i = 0; #1;
    chk("ivec_vec", vector_o, 16'o000123);
    chk("ivec_istb", istb_o, 1);
    chk("ivec_vack", vack_o, 0);
    istb_i = 0;
    cyc();

    // Shadow ROM read with two wait states
    full_adr = 17'o340246; cyc_i = 1; stb_i = 1; #1;
    chk("rom_stb", rom_stb_o, 1);
    chk("rom_buscyc", bus_cyc_o, 0);
    chk("rom_ram", sysram_stb_o, 0);
    chk("rom_dat", dat_o, 16'hBEEF);
    chk("rom_adr", rom_adr_o, 12'h053);
    chk("rom_ack0", ack_o, 0);
    cyc();
    chk("rom_ack1", ack_o, 0);
    cyc();
    chk("rom_ack2", ack_o, 1);
    cyc();
    chk("rom_ack_hold", ack_o, 1);
    stb_i = 0;
    cyc();
    chk("rom_ack_drop", ack_o, 0);
    stb_i = 1; #1;
    chk("rom_restart0", ack_o, 0);
    cyc();
    chk("rom_restart1", ack_o, 0);
    cyc();
    chk("rom_restart2", ack_o, 1);
    stb_i = 0;
    cyc();

    // Shadow system RAM decode
    full_adr = 17'o360000; stb_i = 1; #1;
    chk("ram_stb", sysram_stb_o, 1);
    chk("ram_romstb", rom_stb_o, 0);
    chk("ram_dat", dat_o, 16'h1234);
    stb_i = 0;
    cyc();

    // Global read that times out
    full_adr = 17'o001000; stb_i = 1; #1;
    chk("glb_buscyc", bus_cyc_o, 1);
    pulses = 0; pulse_at = 0;
    for (int i = 1; i <= 70; i++) begin
      cyc();
      if (bus_err_o) begin
        pulses++;
        pulse_at = i;
      end
    end
    chk("tmo_pulses", pulses, 1);
    chk("tmo_cycle", pulse_at, 64);
    chk("tmo_ack", ack_o, 1);
    stb_i = 0; #1;
    chk("tmo_ack_drop", ack_o, 0);
    cyc();

    // Global ack arriving on the expiry cycle suppresses the error
    stb_i = 1;
    repeat (63) cyc();
    chk("race_pre_err", bus_err_o, 0);
    global_ack = 1; #1;
    chk("race_ack", ack_o, 1);
    cyc();
    chk("race_err", bus_err_o, 0);
    global_ack = 0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus_err_o) pulses++;
    end
    chk("race_no_pulse", pulses, 0);
    stb_i = 0; cyc_i = 0;
    cyc();

    // Slow clock enable
    cpuslow = 1; #1;
    chk("slow_first", clk_ena_o, 1);
    ones = 0; first_one = 0;
    for (int i = 1; i <= 44; i++) begin
      cyc();
      if (clk_ena_o) begin
        ones++;
        if (first_one == 0) first_one = i;
      end
    end
    chk("slow_count", ones, 2);
    chk("slow_period", first_one, 22);
    cpuslow = 0;
    ones = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (clk_ena_o) ones++;
    end
    chk("fast_ena", ones, 5);

    // Timer gate: event follows the synchronised timer while enabled
    timer_50 = 1;
    cyc(); cyc();
    chk("evnt_on", evnt_o, 1);
    cyc(); cyc();
    timer_50 = 0;
    repeat (4) cyc();
    chk("evnt_off", evnt_o, 0);

    timer_button = 1;
    tmr_tick();
    chk("btn_1tick", timer_status, 1);
    tmr_tick();
    chk("btn_toggle_off", timer_status, 0);
    tmr_tick(); tmr_tick();
    chk("btn_held", timer_status, 0);
    timer_button = 0;
    tmr_tick(); tmr_tick();
    chk("btn_release", timer_status, 0);
    timer_50 = 1;
    repeat (3) cyc();
    chk("evnt_gated", evnt_o, 0);
    repeat (1) cyc();
    timer_50 = 0;
    repeat (4) cyc();
    timer_button = 1;
    tmr_tick(); tmr_tick();
    chk("btn_toggle_on", timer_status, 1);
    timer_button = 0;
    tmr_tick(); tmr_tick();
    timer_button = 1;
    tmr_tick(); tmr_tick();
    chk("btn_toggle_off2", timer_status, 0);
    timer_button = 0;

    // Reset in the middle of an acknowledged ROM cycle
    cpuslow = 1;
    full_adr = 17'o340000; cyc_i = 1; stb_i = 1;
    cyc(); cyc();
    chk("mid_ack", ack_o, 1);
    chk("mid_ena", clk_ena_o, 0);
    dclo = 1; mode_i = 3'b110;
    cyc();
    chk("mid_rst_ack", ack_o, 0);
    chk("mid_rst_ena", clk_ena_o, 1);
    chk("mid_rst_tstat", timer_status, 1);
    global_ack = 1; #1;
    chk("mid_rst_gack", ack_o, 1);
    global_ack = 0; stb_i = 0; cyc_i = 0; cpuslow = 0;
    cyc();
    dclo = 0; mode_i = 3'b001;
    cyc();
    una_i = 1; #1;
    chk("mode_relatch", vector_o, 16'o140006);
    una_i = 0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
